// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters plus EX-stage branch resolve.
// Define BP_STATS_EN to add the BrCount/MispCount statistics ports.
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic [2:0]      BranchTypeE,
    input  logic [XLEN-1:0] Operand1E,
    input  logic [XLEN-1:0] Operand2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] BrTargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    input  logic            StallE,
    input  logic            FlushE,
    output logic            BranchE,
    output logic            MispredE,
    output logic [XLEN-1:0] RedirectPCE
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     BrCount,
    output logic [31:0]     MispCount
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [2:0] NOBRANCH = 3'd0;
    localparam logic [2:0] BEQ      = 3'd1;
    localparam logic [2:0] BNE      = 3'd2;
    localparam logic [2:0] BLT      = 3'd3;
    localparam logic [2:0] BLTU     = 3'd4;
    localparam logic [2:0] BGE      = 3'd5;
    localparam logic [2:0] BGEU     = 3'd6;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_idxF;
    logic [TAG_W-1:0] w_tagF;
    logic             w_hitF;
    logic [IDX_W-1:0] w_idxE;
    logic [TAG_W-1:0] w_tagE;
    logic             w_hitE;
    logic             w_taken;
    logic             w_isBr;
    logic             w_upd;

    assign w_idxF      = PCF[IDX_W+1:2];
    assign w_tagF      = PCF[XLEN-1:IDX_W+2];
    assign w_hitF      = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);
    assign PredTakenF  = w_hitF && r_ctr[w_idxF][1];
    assign PredTargetF = r_target[w_idxF];

    always_comb begin
        w_taken = 1'b0;
        case (BranchTypeE)
            BEQ:     w_taken = (Operand1E == Operand2E);
            BNE:     w_taken = (Operand1E != Operand2E);
            BLT:     w_taken = ($signed(Operand1E) <  $signed(Operand2E));
            BGE:     w_taken = ($signed(Operand1E) >= $signed(Operand2E));
            BLTU:    w_taken = (Operand1E <  Operand2E);
            BGEU:    w_taken = (Operand1E >= Operand2E);
            default: w_taken = 1'b0;
        endcase
    end

    assign BranchE = w_taken;
    assign w_isBr  = (BranchTypeE != NOBRANCH) && !FlushE;

    // A predicted-taken non-branch is an alias and must fall through
    assign MispredE = !FlushE && (w_isBr
        ? ((w_taken != PredTakenE) ||
           (w_taken && (PredTargetE != BrTargetE)))
        : PredTakenE);

    assign RedirectPCE = w_taken ? BrTargetE : PCE + XLEN'(4);

    assign w_idxE = PCE[IDX_W+1:2];
    assign w_tagE = PCE[XLEN-1:IDX_W+2];
    assign w_hitE = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);
    assign w_upd  = !StallE && !FlushE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_isBr) begin
                if (w_hitE) begin
                    if (w_taken && r_ctr[w_idxE] != 2'b11) begin
                        r_ctr[w_idxE] <= r_ctr[w_idxE] + 2'd1;
                    end else if (!w_taken && r_ctr[w_idxE] != 2'b00) begin
                        r_ctr[w_idxE] <= r_ctr[w_idxE] - 2'd1;
                    end
                end else if (w_taken) begin
                    r_valid[w_idxE] <= 1'b1;
                    r_ctr[w_idxE]   <= 2'b10;
                end
            end else if (PredTakenE) begin
                r_valid[w_idxE] <= 1'b0;
            end
        end
    end

    // Tag/target carry no reset; valid bits alone gate their use
    always_ff @(posedge clk) begin
        if (rst_n && w_upd && w_isBr && w_taken) begin
            r_tag[w_idxE]    <= w_tagE;
            r_target[w_idxE] <= BrTargetE;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_brCnt;
    logic [31:0] r_mispCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brCnt   <= '0;
            r_mispCnt <= '0;
        end else if (w_upd) begin
            if (w_isBr && r_brCnt != 32'hFFFF_FFFF) begin
                r_brCnt <= r_brCnt + 32'd1;
            end
            if (MispredE && r_mispCnt != 32'hFFFF_FFFF) begin
                r_mispCnt <= r_mispCnt + 32'd1;
            end
        end
    end

    assign BrCount   = r_brCnt;
    assign MispCount = r_mispCnt;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed plan then random traffic
// against a table-level reference model.
module tb_branch_predict_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     PCF;
    logic            PredTakenF;
    logic [31:0]     PredTargetF;
    logic [2:0]      BranchTypeE;
    logic [31:0]     Operand1E, Operand2E, PCE, BrTargetE, PredTargetE;
    logic            PredTakenE, StallE, FlushE;
    logic            BranchE, MispredE;
    logic [31:0]     RedirectPCE;
`ifdef BP_STATS_EN
    logic [31:0]     BrCount, MispCount;
`endif

    always #5 clk = ~clk;

    branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .BranchTypeE(BranchTypeE), .Operand1E(Operand1E),
        .Operand2E(Operand2E), .PCE(PCE), .BrTargetE(BrTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .StallE(StallE), .FlushE(FlushE), .BranchE(BranchE),
        .MispredE(MispredE), .RedirectPCE(RedirectPCE)
`ifdef BP_STATS_EN
        , .BrCount(BrCount), .MispCount(MispCount)
`endif
    );

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        br;
        logic        mp;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference table: one record per slot, counter kept as 0..3
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_br, m_misp;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit hit(logic [31:0] pc);
        return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
    endfunction

    function automatic bit pred(logic [31:0] pc);
        return hit(pc) && m_ctr[idx_of(pc)] >= 2;
    endfunction

    function automatic bit resolve(int t, logic [31:0] a, logic [31:0] b);
        case (t)
            1: return a == b;
            2: return a != b;
            3: return $signed(a) < $signed(b);
            4: return a < b;
            5: return $signed(a) >= $signed(b);
            6: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_misp = 0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exv, $time);
        end
    endtask

    // Called at posedge+1: drive inputs, queue expectation, advance model
    task automatic step(logic [31:0] pcf, int bt, logic [31:0] a,
                        logic [31:0] b, logic [31:0] pce, logic [31:0] brt,
                        bit ptk, logic [31:0] ptg, bit stall, bit flush);
        exp_t e;
        int   i;
        bit   tk, isbr;
        PCF = pcf; BranchTypeE = 3'(bt); Operand1E = a; Operand2E = b;
        PCE = pce; BrTargetE = brt; PredTakenE = ptk; PredTargetE = ptg;
        StallE = stall; FlushE = flush;
        tk     = resolve(bt, a, b);
        isbr   = bt != 0 && !flush;
        e.pt   = pred(pcf);
        e.ptgt = m_tgt[idx_of(pcf)];
        e.br   = tk;
        e.mp   = !flush && (isbr ? (tk != ptk || (tk && ptg != brt)) : ptk);
        e.rd   = tk ? brt : pce + 32'd4;
        q.push_back(e);
        if (rst_n && !stall && !flush) begin
            if (isbr) m_br++;
            if (e.mp) m_misp++;
            i = idx_of(pce);
            if (isbr && hit(pce)) begin
                if (tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = brt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (isbr && tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(pce);
                m_tgt[i]   = brt;
                m_ctr[i]   = 2;
            end else if (!isbr && ptk) begin
                m_valid[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Branch whose EX-side prediction is what the IF lookup would have given
    task automatic br(logic [31:0] pcf, int bt, logic [31:0] a,
                      logic [31:0] b, logic [31:0] pce, logic [31:0] brt);
        step(pcf, bt, a, b, pce, brt, pred(pce), m_tgt[idx_of(pce)], 0, 0);
    endtask

    task automatic idle(logic [31:0] pcf);
        step(pcf, 0, 0, 0, 32'h1000, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("PredTakenF", 32'(PredTakenF), 32'(e.pt));
            if (e.pt) chk("PredTargetF", PredTargetF, e.ptgt);
            chk("BranchE", 32'(BranchE), 32'(e.br));
            chk("MispredE", 32'(MispredE), 32'(e.mp));
            chk("RedirectPCE", RedirectPCE, e.rd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] ops [5];
    logic [31:0] pa, pf, tg;

    initial begin
        ops[0] = 32'h0; ops[1] = 32'h1; ops[2] = 32'h5;
        ops[3] = 32'hFFFF_FFFF; ops[4] = 32'h8000_0000;
        for (int i = 0; i < ENTRIES; i++) m_tgt[i] = '0;
        rst_n = 1'b0;
        model_reset();
        PCF = 0; BranchTypeE = 0; Operand1E = 0; Operand2E = 0; PCE = 0;
        BrTargetE = 0; PredTakenE = 0; PredTargetE = 0; StallE = 0; FlushE = 0;
        repeat (2) @(posedge clk);
        #1;
        step(32'h40, 0, 0, 0, 32'h40, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // First taken BEQ allocates; next lookup hits
        step(32'h40, 1, 5, 5, 32'h40, 32'h80, 0, 0, 0, 0);
        idle(32'h40);

        // Signed vs unsigned compares on -1 vs 1
        step(32'h90, 3, 32'hFFFF_FFFF, 1, 32'h50, 32'h90, 0, 0, 0, 1);
        step(32'h90, 4, 32'hFFFF_FFFF, 1, 32'h50, 32'h90, 0, 0, 0, 1);
        step(32'h90, 6, 32'hFFFF_FFFF, 1, 32'h50, 32'h90, 0, 0, 0, 1);

        // Counter walk on the 0x40 entry
        br(32'h40, 1, 1, 2, 32'h40, 32'h80);
        br(32'h40, 1, 1, 2, 32'h40, 32'h80);
        br(32'h40, 1, 1, 2, 32'h40, 32'h80);
        repeat (4) br(32'h40, 1, 3, 3, 32'h40, 32'h80);
        br(32'h40, 1, 1, 2, 32'h40, 32'h80);
        idle(32'h40);

        // Aliasing non-branch invalidates the entry
        step(32'h140, 0, 0, 0, 32'h140, 0, 1, 32'h80, 0, 0);
        idle(32'h40);

        // Stalled and flushed taken BNE leave the table alone
        step(32'h60, 2, 1, 2, 32'h60, 32'hA0, 0, 0, 1, 0);
        idle(32'h60);
        step(32'h60, 2, 1, 2, 32'h60, 32'hA0, 0, 0, 0, 1);
        idle(32'h60);

        // Reset between edges clears prediction and drops the pending write
        br(32'h40, 1, 5, 5, 32'h40, 32'h80);
        idle(32'h40);
        rst_n = 1'b0;
        model_reset();
        step(32'h40, 1, 5, 5, 32'h70, 32'hB0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(32'h70);

        for (int n = 0; n < 300; n++) begin
            pa = 32'h40 + 32'(4 * $urandom_range(0, 3))
               + 32'(4 * ENTRIES * $urandom_range(0, 1));
            pf = 32'h40 + 32'(4 * $urandom_range(0, 3))
               + 32'(4 * ENTRIES * $urandom_range(0, 1));
            tg = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
            if ($urandom_range(0, 3) != 0)
                step(pf, $urandom_range(0, 7), ops[$urandom_range(0, 4)],
                     ops[$urandom_range(0, 4)], pa, tg, pred(pa),
                     m_tgt[idx_of(pa)], $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0);
            else
                step(pf, $urandom_range(0, 6), ops[$urandom_range(0, 4)],
                     ops[$urandom_range(0, 4)], pa, tg,
                     1'($urandom_range(0, 1)), tg, 0, 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef BP_STATS_EN
        chk("BrCount", BrCount, 32'(m_br));
        chk("MispCount", MispCount, 32'(m_misp));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
